// File: rtl/actuator_reg_bank.sv
// Double-buffered actuator register bank: host writes shadow words, a commit request
// copies every shadow word to the active outputs together on the next timer strobe.
module actuator_reg_bank #(
    parameter int DATA_WIDTH   = 16,
    parameter int NUM_CHANNELS = 4,
    parameter int ADDR_WIDTH   = 8
) (
    input  logic                                 clock,
    input  logic                                 reset_sn,
    input  logic                                 memory_enable_n,
    input  logic                                 memory_write_n,
    input  logic                                 memory_read_n,
    input  logic [ADDR_WIDTH-1:0]                memory_address,
    input  logic [DATA_WIDTH-1:0]                memory_data_in,
    output logic [DATA_WIDTH-1:0]                memory_data_out,
    output logic                                 memory_data_valid,
    input  logic                                 update_strobe,
    output logic [DATA_WIDTH-1:0]                cell_state,
    output logic [2*DATA_WIDTH*NUM_CHANNELS-1:0] ccr,
    output logic                                 commit_done,
    output logic                                 write_error
);

    localparam int NUM_WORDS = 2 * NUM_CHANNELS;
    localparam int LAST_ADDR = 1 + 2 * NUM_CHANNELS;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } commit_state_t;

    commit_state_t state_reg, state_next;

    logic [DATA_WIDTH-1:0] cell_shadow_reg;
    logic [DATA_WIDTH-1:0] cell_active_reg;
    logic [DATA_WIDTH-1:0] ccr_shadow_reg [NUM_WORDS];
    logic [DATA_WIDTH-1:0] ccr_active_reg [NUM_WORDS];
    logic                  lock_reg;

    logic [DATA_WIDTH-1:0] memory_data_out_reg;
    logic                  memory_data_valid_reg;
    logic                  commit_done_reg;
    logic                  write_error_reg;

    logic                  bus_write;
    logic                  bus_read;
    logic                  addr_mapped;
    logic                  addr_is_cell;
    logic                  addr_is_ctrl;
    logic                  write_reject;
    logic                  write_accept;
    logic                  commit_request;
    logic                  transfer;
    logic [DATA_WIDTH-1:0] ctrl_word;
    logic [DATA_WIDTH-1:0] read_word;

    assign bus_write      = !memory_enable_n && !memory_write_n;
    assign bus_read       = !memory_enable_n && !memory_read_n;
    assign addr_mapped    = memory_address <= ADDR_WIDTH'(LAST_ADDR);
    assign addr_is_cell   = memory_address == ADDR_WIDTH'(0);
    assign addr_is_ctrl   = memory_address == ADDR_WIDTH'(1);

    // CTRL stays writable under LOCK so the host can always unlock and commit.
    assign write_reject   = bus_write && (!addr_mapped || (lock_reg && !addr_is_ctrl));
    assign write_accept   = bus_write && !write_reject;
    assign commit_request = write_accept && addr_is_ctrl && memory_data_in[0];
    assign transfer       = (state_reg == PENDING) && update_strobe;

    assign ctrl_word = {{(DATA_WIDTH-2){1'b0}}, lock_reg, state_reg == PENDING};

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (commit_request) state_next = PENDING;
            PENDING: if (update_strobe && !commit_request) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_sn) begin
        if (!reset_sn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Read mux sees only pre-edge register values, so a same-cycle write is not visible.
    always_comb begin
        read_word = '0;
        if (addr_is_cell) begin
            read_word = cell_shadow_reg;
        end else if (addr_is_ctrl) begin
            read_word = ctrl_word;
        end
        for (int i = 0; i < NUM_WORDS; i++) begin
            if (memory_address == ADDR_WIDTH'(i + 2)) begin
                read_word = ccr_shadow_reg[i];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_sn) begin
        if (!reset_sn) begin
            memory_data_out_reg   <= '0;
            memory_data_valid_reg <= 1'b0;
            commit_done_reg       <= 1'b0;
            write_error_reg       <= 1'b0;
            lock_reg              <= 1'b0;
            cell_shadow_reg       <= '0;
            cell_active_reg       <= '0;
        end else begin
            memory_data_out_reg   <= bus_read ? read_word : '0;
            memory_data_valid_reg <= bus_read;
            commit_done_reg       <= transfer;
            write_error_reg       <= write_reject;
            if (write_accept && addr_is_ctrl) begin
                lock_reg <= memory_data_in[1];
            end
            if (write_accept && addr_is_cell) begin
                cell_shadow_reg <= memory_data_in;
            end
            if (transfer) begin
                cell_active_reg <= cell_shadow_reg;
            end
        end
    end

    // Word 2k is the low half and word 2k+1 the high half of channel k.
    generate
        for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_ccr_word
            always_ff @(posedge clock or negedge reset_sn) begin
                if (!reset_sn) begin
                    ccr_shadow_reg[gi] <= '0;
                    ccr_active_reg[gi] <= '0;
                end else begin
                    if (write_accept && memory_address == ADDR_WIDTH'(gi + 2)) begin
                        ccr_shadow_reg[gi] <= memory_data_in;
                    end
                    if (transfer) begin
                        ccr_active_reg[gi] <= ccr_shadow_reg[gi];
                    end
                end
            end
            assign ccr[gi*DATA_WIDTH +: DATA_WIDTH] = ccr_active_reg[gi];
        end
    endgenerate

    assign memory_data_out   = memory_data_out_reg;
    assign memory_data_valid = memory_data_valid_reg;
    assign cell_state        = cell_active_reg;
    assign commit_done       = commit_done_reg;
    assign write_error       = write_error_reg;

endmodule

// File: tb/tb_actuator_reg_bank.sv
// Bench for actuator_reg_bank: directed scenarios with literal expectations, then
// random bus traffic compared every cycle against an address-indexed memory model.
module tb_actuator_reg_bank;

    localparam int DW = 16;
    localparam int NC = 4;
    localparam int AW = 8;
    localparam int NADDR = 2 + 2 * NC;

    logic              clock = 1'b0;
    logic              reset_sn = 1'b0;
    logic              en_n = 1'b1;
    logic              wr_n = 1'b1;
    logic              rd_n = 1'b1;
    logic [AW-1:0]     addr = '0;
    logic [DW-1:0]     din = '0;
    logic [DW-1:0]     dout;
    logic              dvalid;
    logic              strobe = 1'b0;
    logic [DW-1:0]     cell_state;
    logic [2*DW*NC-1:0] ccr;
    logic              commit_done;
    logic              write_error;

    int checks = 0;
    int errors = 0;

    actuator_reg_bank #(.DATA_WIDTH(DW), .NUM_CHANNELS(NC), .ADDR_WIDTH(AW)) dut (
        .clock             (clock),
        .reset_sn          (reset_sn),
        .memory_enable_n   (en_n),
        .memory_write_n    (wr_n),
        .memory_read_n     (rd_n),
        .memory_address    (addr),
        .memory_data_in    (din),
        .memory_data_out   (dout),
        .memory_data_valid (dvalid),
        .update_strobe     (strobe),
        .cell_state        (cell_state),
        .ccr               (ccr),
        .commit_done       (commit_done),
        .write_error       (write_error)
    );

    always #5 clock = ~clock;

    // Model: shadow[] and active[] are indexed by bus address (index 1 unused).
    logic [DW-1:0] m_shadow [NADDR];
    logic [DW-1:0] m_active [NADDR];
    logic          m_lock = 1'b0;
    logic          m_pending = 1'b0;
    logic [DW-1:0] e_dout = '0;
    logic          e_valid = 1'b0;
    logic          e_done = 1'b0;
    logic          e_err = 1'b0;

    function automatic logic [2*DW*NC-1:0] model_ccr();
        logic [2*DW*NC-1:0] v;
        for (int k = 0; k < NC; k++) begin
            v[k*2*DW +: 2*DW] = {m_active[3+2*k], m_active[2+2*k]};
        end
        return v;
    endfunction

    always @(posedge clock or negedge reset_sn) begin
        int a;
        logic w, r, rej;
        if (!reset_sn) begin
            for (int i = 0; i < NADDR; i++) begin
                m_shadow[i] = '0;
                m_active[i] = '0;
            end
            m_lock = 0; m_pending = 0;
            e_dout = '0; e_valid = 0; e_done = 0; e_err = 0;
        end else begin
            a = int'(addr);
            w = !en_n && !wr_n;
            r = !en_n && !rd_n;
            e_valid = r;
            e_dout = '0;
            if (r) begin
                if (a == 1) e_dout = {{(DW-2){1'b0}}, m_lock, m_pending};
                else if (a < NADDR) e_dout = m_shadow[a];
            end
            rej = w && (a >= NADDR || (m_lock && a != 1));
            e_err = rej;
            e_done = m_pending && strobe;
            if (e_done) begin
                for (int i = 0; i < NADDR; i++) m_active[i] = m_shadow[i];
                m_pending = 0;
            end
            if (w && !rej) begin
                if (a == 1) begin
                    m_lock = din[1];
                    if (din[0]) m_pending = 1;
                end else begin
                    m_shadow[a] = din;
                end
            end
        end
    end

    always @(negedge clock) begin
        checks++;
        if (dout !== e_dout || dvalid !== e_valid) begin
            errors++;
            $display("FAIL read_port: got data=%h valid=%b, expected data=%h valid=%b", dout, dvalid, e_dout, e_valid);
        end
        checks++;
        if (cell_state !== m_active[0] || ccr !== model_ccr()) begin
            errors++;
            $display("FAIL active_regs: got cell=%h ccr=%h, expected cell=%h ccr=%h", cell_state, ccr, m_active[0], model_ccr());
        end
        checks++;
        if (commit_done !== e_done || write_error !== e_err) begin
            errors++;
            $display("FAIL pulses: got done=%b err=%b, expected done=%b err=%b", commit_done, write_error, e_done, e_err);
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end else begin
            $display("ok   %s = %h", name, got);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        en_n = 1; wr_n = 1; rd_n = 1;
    endtask

    task automatic bus_wr(input int a, input logic [DW-1:0] d);
        en_n = 0; wr_n = 0; rd_n = 1; addr = AW'(a); din = d;
        tick();
        idle();
    endtask

    task automatic bus_rd(input int a);
        en_n = 0; wr_n = 1; rd_n = 0; addr = AW'(a);
        tick();
        idle();
    endtask

    initial begin
        // Reset held while the bus is busy.
        en_n = 0; wr_n = 0; rd_n = 0; addr = 0; din = 16'hFFFF; strobe = 1;
        repeat (3) tick();
        check("reset_dout", 64'(dout), 64'h0);
        check("reset_ccr_cell", 64'(|{ccr, cell_state, commit_done, write_error, dvalid}), 64'h0);
        idle(); strobe = 0;
        reset_sn = 1;
        tick();
        bus_rd(1);
        check("ctrl_after_reset", 64'({dvalid, dout}), 64'h1_0000);

        bus_wr(4, 16'h1234);
        bus_wr(5, 16'hABCD);
        bus_rd(4);
        check("ccr1_lo_read", 64'({dvalid, dout}), 64'h1_1234);
        bus_rd(5);
        check("ccr1_hi_read", 64'({dvalid, dout}), 64'h1_ABCD);
        tick();
        check("read_valid_clears", 64'(dvalid), 64'h0);
        check("ccr1_uncommitted", 64'(ccr[32 +: 32]), 64'h0);

        bus_wr(1, 16'h0001);
        repeat (5) tick();
        check("ccr1_before_strobe", 64'(ccr[32 +: 32]), 64'h0);
        strobe = 1;
        tick();
        strobe = 0;
        check("ccr1_at_strobe", 64'(ccr[32 +: 32]), 64'hABCD1234);
        check("commit_done_pulse", 64'(commit_done), 64'h1);
        tick();
        check("commit_done_single", 64'(commit_done), 64'h0);
        bus_rd(1);
        check("ctrl_pending_clear", 64'({dvalid, dout}), 64'h1_0000);

        bus_wr(0, 16'h00FF);
        bus_wr(1, 16'h0001);
        en_n = 0; wr_n = 0; addr = 0; din = 16'h5555; strobe = 1;
        tick();
        idle(); strobe = 0;
        check("commit_vs_write_old", 64'(cell_state), 64'h00FF);
        bus_wr(1, 16'h0001);
        strobe = 1;
        tick();
        strobe = 0;
        check("commit_vs_write_new", 64'(cell_state), 64'h5555);

        bus_wr(1, 16'h0002);
        bus_wr(2, 16'h9999);
        check("locked_write_error", 64'(write_error), 64'h1);
        bus_rd(2);
        check("locked_shadow_kept", 64'({dvalid, dout}), 64'h1_0000);
        bus_wr(NADDR, 16'h7777);
        check("unmapped_write_error", 64'(write_error), 64'h1);
        bus_rd(NADDR);
        check("unmapped_read", 64'({dvalid, dout}), 64'h1_0000);
        bus_rd(1);
        check("ctrl_lock_read", 64'({dvalid, dout}), 64'h1_0002);
        bus_wr(1, 16'h0000);

        bus_wr(1, 16'h0001);
        reset_sn = 0;
        #2;
        reset_sn = 1;
        strobe = 1;
        tick();
        strobe = 0;
        check("reset_drops_commit", 64'(commit_done), 64'h0);
        check("reset_active_zero", 64'(|{ccr, cell_state}), 64'h0);

        // Random traffic, occasional async reset pulses.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                reset_sn = 0;
                #2;
                reset_sn = 1;
            end
            en_n = ($urandom_range(0, 3) == 0);
            wr_n = $urandom_range(0, 1) == 0;
            rd_n = $urandom_range(0, 1) == 0;
            addr = AW'($urandom_range(0, NADDR + 1));
            din = DW'($urandom);
            if (addr == 1) din = DW'(($urandom_range(0, 3) == 0) ? 2 : 0) | DW'($urandom_range(0, 1));
            strobe = ($urandom_range(0, 7) == 0);
            tick();
        end
        idle(); strobe = 0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/actuator_reg_bank.md
# actuator_reg_bank

Parametrised, double-buffered register bank holding the cell-state word and per-channel 32-bit compare (CCR) values for the actuator channels. A host bus writes shadow registers. Shadow contents move atomically to the active outputs on the next timer period strobe after a commit request, so a channel never sees a half-updated compare value. The bank sits between the host interface and the channel PWM/compare engines.

## Interface
Parameters:
- DATA_WIDTH, 16, width of one register word; CCR width is 2*DATA_WIDTH
- NUM_CHANNELS, 4, number of CCR channels (1..64)
- ADDR_WIDTH, 8, bus address width; require 2+2*NUM_CHANNELS <= 2**ADDR_WIDTH

Ports:
- clock  in  1  rising-edge clock
- reset_sn  in  1  reset, asynchronous, active-low
- memory_enable_n  in  1  bus select, active-low
- memory_write_n  in  1  write strobe, active-low
- memory_read_n  in  1  read strobe, active-low
- memory_address  in  ADDR_WIDTH  word address
- memory_data_in  in  DATA_WIDTH  write data
- memory_data_out  out  DATA_WIDTH  registered read data
- memory_data_valid  out  1  one-cycle pulse qualifying memory_data_out
- update_strobe  in  1  period boundary from the timer; transfer point for commits
- cell_state  out  DATA_WIDTH  active cell-state word
- ccr  out  2*DATA_WIDTH*NUM_CHANNELS  active CCRs; channel k = ccr[k*2W +: 2W] = {hi,lo}
- commit_done  out  1  one-cycle pulse when shadow→active transfer occurs
- write_error  out  1  one-cycle pulse on a rejected write

## Operation
- Address map:
  - 0: cell-state shadow
  - 1: CTRL
    - bit0 COMMIT: write 1 sets commit_pending
    - bit1 LOCK: read/write
    - reads return {0…, LOCK, commit_pending}
  - 2+2k: CCR k low word
  - 3+2k: CCR k high word
  - anything above 1+2*NUM_CHANNELS is unmapped
- Write: sampled at posedge when enable_n=0 and write_n=0.
  - Mapped, unlocked address: shadow word <= memory_data_in.
  - CTRL: always writable. Writing COMMIT=0 does not clear a pending commit.
  - LOCK=1 and address is 0 or a CCR word: write ignored, write_error pulses.
  - Unmapped address: write ignored, write_error pulses.
- Read: sampled at posedge when enable_n=0 and read_n=0.
  - Next cycle: memory_data_out = addressed shadow/CTRL value and memory_data_valid=1.
  - Unmapped address: data 0, valid still 1.
  - When no read is sampled: memory_data_out=0 and valid=0.
- Simultaneous read and write to the same address: read returns the pre-write value.
- Commit state machine, two states:
  - IDLE → PENDING on a COMMIT=1 write.
  - PENDING → IDLE on the first posedge where update_strobe=1. At that edge:
    - all active registers (cell_state, every CCR word) <= shadow
    - commit_done pulses the following cycle
  - COMMIT write while already PENDING: stays PENDING, no extra transfer.
- Commit edge coinciding with a shadow write: active takes the pre-write shadow; shadow takes the new data.
- COMMIT write in the same cycle as update_strobe: pending is set at that edge. The transfer waits for the next strobe.
- LOCK does not block commits.

## Timing
- Reset (reset_sn=0, asynchronous) clears all of the following to 0:
  - shadow and active registers, LOCK, commit_pending
  - memory_data_out, memory_data_valid, commit_done, write_error
- Outputs stay 0 until the first posedge after release.
- Reset asserted while PENDING: the commit is dropped, and active outputs are 0.
- Write latency: shadow visible to a read issued the next cycle.
- Read latency: 1 cycle.
- Commit latency: active outputs change at the strobe edge. commit_done is high for exactly the one cycle after that edge.
- write_error is high for the one cycle after the rejected write edge.
- All outputs are registered; no combinational path from bus inputs to outputs.

## Test plan
- Reset with non-zero bus activity → all outputs 0. CTRL read returns 0x0000 with valid one cycle after the read.
- Write CCR1 lo=0x1234 and hi=0xABCD, read both back → 0x1234 then 0xABCD, each with a 1-cycle valid pulse. ccr channel 1 stays 0 (not committed).
- Write COMMIT, hold update_strobe low for 5 cycles, then pulse it:
  - ccr channel 1 = 0xABCD1234 only at the strobe edge
  - commit_done pulses once
  - CTRL bit0 reads 0 afterwards
- Commit edge coincides with a write of 0x5555 to addr 0 (prior shadow 0x00FF) → cell_state=0x00FF. The next commit gives 0x5555.
- Set LOCK, write 0x9999 to addr 2 → write_error pulses and the shadow is unchanged. Write to addr 2*NUM_CHANNELS+2 → write_error pulses and the read returns 0 with valid.
- Assert reset_sn mid-PENDING, then strobe after release → no commit_done, ccr remains 0.
